// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package reg_file_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int NUM_RD_DEF   = 2;
  localparam int CNT_W_DEF    = 2;
  localparam int ZERO_REG_DEF = 1;

  // Widest packed bus and widest single slice the helper can handle.
  localparam int SLICE_BUS_W = 512;
  localparam int SLICE_W     = 64;

  // Extract field idx of width w from a packed bus (field 0 in the LSBs).
  function automatic logic [SLICE_W-1:0] port_slice(
    input logic [SLICE_BUS_W-1:0] bus,
    input int                     idx,
    input int                     w
  );
    logic [SLICE_BUS_W-1:0] shifted;
    shifted = bus >> (idx * w);
    return SLICE_W'(shifted) & ((SLICE_W'(1'b1) << w) - SLICE_W'(1'b1));
  endfunction

endpackage

// File: rtl/reg_file_sb_cnt.sv
// Per-register pending-write counter: issue increments, writeback decrements,
// flush clears. Also reports saturation and whether the post-writeback count
// is nonzero.
module reg_file_sb_cnt #(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output logic sat,
  output logic busy_nxt
);

  logic [CNT_W-1:0] cnt;

  assign sat = &cnt;

  // Next-state nonzero test, ignoring any same-cycle increment.
  always_comb begin
    busy_nxt = 1'b0;
    if (clr) begin
      busy_nxt = 1'b0;
    end else if (dec) begin
      busy_nxt = (cnt > CNT_W'(1'b1));
    end else begin
      busy_nxt = (cnt != {CNT_W{1'b0}});
    end
  end

  // Counter update: clear wins; paired inc/dec cancel; no wrap at either end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt <= {CNT_W{1'b0}};
    end else if (inc && !dec && !sat) begin
      cnt <= cnt + CNT_W'(1'b1);
    end else if (dec && !inc && (cnt != {CNT_W{1'b0}})) begin
      cnt <= cnt - CNT_W'(1'b1);
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with write-through bypass reads and a per-register
// scoreboard of outstanding writes used to gate instruction issue.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     iss_ok,
  input  logic                     flush
);

  localparam int DEPTH   = 2 ** ADDR_W;
  localparam bit ZERO_EN = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  inc_vec;
  logic [DEPTH-1:0]  dec_vec;
  logic [DEPTH-1:0]  sat_vec;
  logic [DEPTH-1:0]  busy_nxt_vec;
  logic              wr_ok;
  logic              iss_zero;
  logic              iss_wb_hit;

  // Register 0 is hardwired when ZERO_EN, so writes to it are dropped.
  assign wr_ok      = wr_en && !(ZERO_EN && (wr_addr == {ADDR_W{1'b0}}));
  assign iss_zero   = ZERO_EN && (iss_addr == {ADDR_W{1'b0}});
  assign iss_wb_hit = wr_ok && (wr_addr == iss_addr);

  // Issue acceptance: refused in reset, on flush, for r0, or when the
  // destination counter is full and not being drained this cycle.
  always_comb begin
    iss_ok = 1'b0;
    if (!rst_n) begin
      iss_ok = 1'b0;
    end else if (flush || iss_zero) begin
      iss_ok = 1'b0;
    end else if (sat_vec[iss_addr] && !iss_wb_hit) begin
      iss_ok = 1'b0;
    end else begin
      iss_ok = iss_en;
    end
  end

  for (genvar r = 0; r < DEPTH; r++) begin : g_cnt
    assign inc_vec[r] = iss_ok && (iss_addr == ADDR_W'(r));
    assign dec_vec[r] = wr_ok && (wr_addr == ADDR_W'(r));

    reg_file_sb_cnt #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (inc_vec[r]),
      .dec      (dec_vec[r]),
      .clr      (flush),
      .sat      (sat_vec[r]),
      .busy_nxt (busy_nxt_vec[r])
    );
  end

  // Flop-based storage so that reset clears every register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs[r] <= {DATA_W{1'b0}};
      end
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read ports: forced low in reset, r0 reads zero, writeback data bypasses.
  always_comb begin
    logic [ADDR_W-1:0] idx;
    rd_data = {(NUM_RD*DATA_W){1'b0}};
    rd_busy = {NUM_RD{1'b0}};
    for (int i = 0; i < NUM_RD; i++) begin
      idx = ADDR_W'(port_slice(SLICE_BUS_W'(rd_addr), i, ADDR_W));
      if (!rst_n) begin
        rd_data[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
        rd_busy[i]                  = 1'b0;
      end else if (ZERO_EN && (idx == {ADDR_W{1'b0}})) begin
        rd_data[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
        rd_busy[i]                  = 1'b0;
      end else if (wr_ok && (wr_addr == idx)) begin
        rd_data[i*DATA_W +: DATA_W] = wr_data;
        rd_busy[i]                  = busy_nxt_vec[idx];
      end else begin
        rd_data[i*DATA_W +: DATA_W] = regs[idx];
        rd_busy[i]                  = busy_nxt_vec[idx];
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus random traffic
// compared against an array-based model of the register file and scoreboard.
module tb_reg_file_sb;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  ra0;
  logic [4:0]  ra1;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic        iss_ok;
  logic        flush;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Model state: register contents and number of outstanding writes.
  logic [31:0] m_mem [32];
  int          m_cnt [32];

  assign rd_addr = {ra1, ra0};

  reg_file_sb dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .iss_ok   (iss_ok),
    .flush    (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (!rst_n || a == 5'd0) return 32'd0;
    if (wr_en && wr_addr == a) return wr_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    int c;
    if (!rst_n || flush) return 1'b0;
    c = m_cnt[a];
    if (wr_en && wr_addr == a && a != 5'd0 && c > 0) c = c - 1;
    return (c != 0);
  endfunction

  function automatic logic exp_iss();
    if (!rst_n || !iss_en || flush || iss_addr == 5'd0) return 1'b0;
    if (m_cnt[iss_addr] == 3 && !(wr_en && wr_addr == iss_addr)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin
      m_mem[r] = 32'd0;
      m_cnt[r] = 0;
    end
  endtask

  task automatic model_edge();
    logic ok;
    logic wb;
    if (!rst_n) begin
      model_clear();
      return;
    end
    ok = exp_iss();
    wb = wr_en && (wr_addr != 5'd0);
    if (wb) m_mem[wr_addr] = wr_data;
    if (flush) begin
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    end else if (!(ok && wb && wr_addr == iss_addr)) begin
      if (ok) m_cnt[iss_addr] = m_cnt[iss_addr] + 1;
      if (wb && m_cnt[wr_addr] > 0) m_cnt[wr_addr] = m_cnt[wr_addr] - 1;
    end
  endtask

  task automatic setin(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic ie, input logic [4:0] ia, input logic fl,
                       input logic [4:0] a0, input logic [4:0] a1);
    wr_en = we; wr_addr = wa; wr_data = wd;
    iss_en = ie; iss_addr = ia; flush = fl;
    ra0 = a0; ra1 = a1;
  endtask

  // Let inputs settle, then compare every output with the model.
  task automatic check_model(input string tag);
    #3;
    chk({tag, "/rd0"},  rd_data[31:0],  exp_rd(ra0));
    chk({tag, "/rd1"},  rd_data[63:32], exp_rd(ra1));
    chk({tag, "/bsy0"}, {31'd0, rd_busy[0]}, {31'd0, exp_busy(ra0)});
    chk({tag, "/bsy1"}, {31'd0, rd_busy[1]}, {31'd0, exp_busy(ra1)});
    chk({tag, "/iss"},  {31'd0, iss_ok},     {31'd0, exp_iss()});
  endtask

  task automatic advance();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag);
    check_model(tag);
    advance();
  endtask

  initial begin
    model_clear();
    rst_n = 1'b0;
    // Write and issue attempted during reset must leave no trace.
    setin(1'b1, 5'd5, 32'hA5A5A5A5, 1'b1, 5'd5, 1'b0, 5'd5, 5'd5);
    #1;
    step("rst_a");
    step("rst_b");
    rst_n = 1'b1;
    setin(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd5);
    check_model("post_rst");
    chk("rst_discard", rd_data[31:0], 32'd0);
    advance();

    // Write r5, read it back one cycle later.
    setin(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd1, 5'd2);
    step("wr_r5");
    setin(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd5);
    check_model("rd_r5");
    chk("r5_value", rd_data[31:0], 32'hDEADBEEF);
    chk("r5_dup_port", rd_data[63:32], 32'hDEADBEEF);
    advance();

    // Bypass of same-cycle writeback; r0 stays zero.
    setin(1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 1'b0, 5'd5, 5'd7);
    check_model("byp_r7");
    chk("byp_r7_val", rd_data[63:32], 32'h12345678);
    advance();
    setin(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 1'b0, 5'd0, 5'd7);
    check_model("wr_r0");
    chk("r0_bypass", rd_data[31:0], 32'd0);
    advance();
    setin(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd7);
    step("rd_r0");

    // Saturate r3 and probe the full-counter rules.
    for (int k = 0; k < 3; k++) begin
      setin(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd0);
      check_model("iss_r3");
      chk("iss_r3_ok", {31'd0, iss_ok}, 32'd1);
      advance();
    end
    check_model("r3_full");
    chk("r3_full_ok", {31'd0, iss_ok}, 32'd0);
    chk("r3_full_busy", {31'd0, rd_busy[0]}, 32'd1);
    advance();
    setin(1'b1, 5'd3, 32'h0000_0333, 1'b1, 5'd3, 1'b0, 5'd3, 5'd3);
    check_model("r3_full_wb");
    chk("r3_full_wb_ok", {31'd0, iss_ok}, 32'd1);
    advance();
    setin(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd0);
    check_model("r3_still_full");
    chk("r3_still_full_ok", {31'd0, iss_ok}, 32'd0);
    advance();

    // Drain r9 with two writebacks.
    setin(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd9, 5'd0);
    step("iss_r9_a");
    step("iss_r9_b");
    setin(1'b1, 5'd9, 32'h99990001, 1'b0, 5'd0, 1'b0, 5'd9, 5'd0);
    step("wb_r9_a");
    setin(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd0);
    check_model("r9_mid");
    chk("r9_busy_mid", {31'd0, rd_busy[0]}, 32'd1);
    advance();
    setin(1'b1, 5'd9, 32'h99990002, 1'b0, 5'd0, 1'b0, 5'd9, 5'd0);
    check_model("wb_r9_b");
    chk("r9_busy_last", {31'd0, rd_busy[0]}, 32'd0);
    advance();

    // Flush with pending counts on r2 and r4.
    setin(1'b1, 5'd2, 32'h22222222, 1'b0, 5'd0, 1'b0, 5'd2, 5'd4);
    step("wr_r2");
    setin(1'b1, 5'd4, 32'h44444444, 1'b1, 5'd2, 1'b0, 5'd2, 5'd4);
    step("wr_r4_iss_r2");
    for (int k = 0; k < 3; k++) begin
      setin(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b0, 5'd2, 5'd4);
      step("iss_r4");
    end
    setin(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 1'b1, 5'd2, 5'd4);
    check_model("flush");
    chk("flush_iss", {31'd0, iss_ok}, 32'd0);
    advance();
    setin(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd2, 5'd4);
    check_model("post_flush");
    chk("flush_busy", {30'd0, rd_busy}, 32'd0);
    chk("flush_r2", rd_data[31:0], 32'h22222222);
    chk("flush_r4", rd_data[63:32], 32'h44444444);
    advance();

    // Random traffic over a small address window to force collisions.
    for (int n = 0; n < 400; n++) begin
      setin(($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)),
            ($urandom_range(0, 24) == 0),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      step("rnd");
    end

    // Asynchronous reset between edges.
    setin(1'b1, 5'd5, 32'hCAFEF00D, 1'b1, 5'd6, 1'b0, 5'd5, 5'd5);
    #2;
    chk("pre_arst_rd", rd_data[31:0], 32'hCAFEF00D);
    rst_n = 1'b0;
    #1;
    chk("arst_rd0", rd_data[31:0], 32'd0);
    chk("arst_rd1", rd_data[63:32], 32'd0);
    chk("arst_busy", {30'd0, rd_busy}, 32'd0);
    chk("arst_iss", {31'd0, iss_ok}, 32'd0);
    model_clear();
    @(posedge clk);
    #1;
    step("arst_hold");
    rst_n = 1'b1;
    setin(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd7);
    check_model("arst_after");
    chk("arst_r5_clear", rd_data[31:0], 32'd0);
    advance();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter DATA_W, 32, register width in bits.
REQ-002 Parameter ADDR_W, 5, address width; depth is 2**ADDR_W registers.
REQ-003 Parameter NUM_RD, 2, number of independent read ports.
REQ-004 Parameter CNT_W, 2, width of each register's pending-write counter.
REQ-005 Parameter ZERO_REG, 1, when 1 register 0 reads as zero, ignores writes and is never pending.
REQ-006 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 wr_en  in  1  writeback strobe.
REQ-010 wr_addr  in  ADDR_W  writeback destination.
REQ-011 wr_data  in  DATA_W  writeback value.
REQ-012 rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
REQ-013 rd_data  out  NUM_RD*DATA_W  packed read data, combinational.
REQ-014 rd_busy  out  NUM_RD  read-port register has an outstanding write after this cycle's writeback.
REQ-015 iss_en  in  1  issue request: reserve iss_addr as a pending destination.
REQ-016 iss_addr  in  ADDR_W  issued destination.
REQ-017 iss_ok  out  1  issue accepted this cycle, combinational.
REQ-018 flush  in  1  synchronous clear of all pending counters; register data is kept.

Function
REQ-019 Writes SHALL occur at the rising clk edge when wr_en=1, except to register 0 when ZERO_REG=1.
REQ-020 rd_data[i] SHALL bypass: wr_data when wr_en=1, wr_addr==rd_addr[i] and the target is writable; otherwise stored value; 0 for address 0 when ZERO_REG=1.
REQ-021 Each register SHALL own a pending counter cnt[r] of width CNT_W.
- accepted issue increments it.
- wr_en decrements it if nonzero.
- decrement at zero is ignored; the write still occurs.
REQ-022 Issue and writeback to the same register in one cycle SHALL leave cnt unchanged.
REQ-023 iss_ok SHALL be 0 when any of these holds, else equal iss_en:
- cnt[iss_addr] is all ones and no same-cycle writeback to iss_addr;
- flush=1;
- iss_addr==0 with ZERO_REG=1 (refused, no state change).
REQ-024 rd_busy[i] SHALL be 1 iff the next-state cnt[rd_addr[i]] excluding any same-cycle issue is nonzero.
REQ-025 flush=1 SHALL zero all counters at the next edge, take priority over iss_en, and still let a same-cycle write update data.
REQ-026 Read ports SHALL be fully independent; identical addresses on several ports return identical data.

Reset
REQ-027 rst_n=0 SHALL asynchronously clear all registers and all counters to 0.
REQ-028 While rst_n=0, outputs SHALL be: rd_data=0, rd_busy=0, iss_ok=0.
REQ-029 A write or issue coincident with reset assertion SHALL be discarded.

Structure
REQ-030 Package reg_file_pkg SHALL hold the default parameter constants and a function for extracting a packed port slice.
REQ-031 The per-register counter SHALL be a sub-module reg_file_sb_cnt (inc, dec, clr, sat flag), instantiated 2**ADDR_W times via generate.
REQ-032 Storage SHALL be flip-flops, not inferred RAM, so reset clears contents.

Verification
REQ-033 Reset, then write 0xDEADBEEF to r5; the next cycle rd_addr[0]=5 -> rd_data[0]=0xDEADBEEF.
REQ-034 Same-cycle bypass: wr_en with r7=0x12345678 and rd_addr[1]=7 -> rd_data[1]=0x12345678 before the edge; r0 write of 0xFFFFFFFF -> r0 reads 0.
REQ-035 Counter saturation (CNT_W=2): issue r3 three times -> iss_ok=1 each time and rd_busy=1 on r3.
- 4th issue -> iss_ok=0.
- 4th issue plus same-cycle writeback to r3 -> iss_ok=1 and cnt stays 3.
REQ-036 Busy drain: issue r9 twice, then write r9 twice -> rd_busy=1 after the first write, 0 during the second write cycle.
REQ-037 Flush: cnt r2=1, r4=3, then flush plus iss_en on r2 -> iss_ok=0 and all rd_busy=0 next cycle; data of r2/r4 unchanged.
REQ-038 Asynchronous reset mid-operation: drop rst_n between edges -> rd_data and rd_busy go 0 immediately, with no clock edge needed.
